// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC3 data-memory access controller.
// Covers request encodings, FSM states and the word width.
package lc3_mem_pkg;

   localparam int LC3_WORD_W = 16;

   typedef enum logic [1:0] {
      REQ_LD  = 2'b00,
      REQ_ST  = 2'b01,
      REQ_LDI = 2'b10,
      REQ_STI = 2'b11
   } req_type_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_PTR    = 2'b01,
      S_ACCESS = 2'b10,
      S_DONE   = 2'b11
   } state_e;

   // Bit 0 of the encoding selects store, bit 1 selects the indirect form.
   function automatic logic is_store(input req_type_e t);
      return t[0];
   endfunction

   function automatic logic is_indirect(input req_type_e t);
      return t[1];
   endfunction

endpackage

// File: rtl/lc3_mem_access.sv
// Initiator side of the LC3 word-addressed data memory port.
// Sequences LD/ST and the two-access LDI/STI forms, one request at a time.
module lc3_mem_access
   import lc3_mem_pkg::*;
#(
   parameter int DATA_W = LC3_WORD_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_type,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_complete
);

   state_e            r_state;
   state_e            w_next;
   req_type_e         r_type;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rsp_data;
   logic              w_ready;
   logic              w_rsp_valid;
   logic              w_mem_rd;

   always_comb begin
      w_next      = r_state;
      w_ready     = 1'b0;
      w_rsp_valid = 1'b0;
      w_mem_rd    = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (req_valid) begin
               w_next = is_indirect(req_type_e'(req_type)) ? S_PTR : S_ACCESS;
            end
         end
         S_PTR: begin
            if (mem_complete) w_next = S_ACCESS;
         end
         S_ACCESS: begin
            // The memory writes whenever rd is low, so only a store access drops it.
            w_mem_rd = ~is_store(r_type);
            if (mem_complete) w_next = S_DONE;
         end
         S_DONE: begin
            w_rsp_valid = 1'b1;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_type     <= REQ_LD;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rsp_data <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_type  <= req_type_e'(req_type);
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
               end
            end
            S_PTR: begin
               // Pointer word replaces the address for the real access.
               if (mem_complete) r_addr <= mem_dout;
            end
            S_ACCESS: begin
               if (mem_complete && !is_store(r_type)) r_rsp_data <= mem_dout;
            end
            default: ;
         endcase
      end
   end

   // r_addr only changes on accept or pointer capture, so it also holds the
   // last driven address through IDLE and DONE.
   assign req_ready = w_ready;
   assign rsp_valid = w_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign mem_addr  = r_addr;
   assign mem_din   = r_wdata;
   assign mem_rd    = w_mem_rd;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Scoreboard bench for lc3_mem_access with a combinational memory model.
module tb_lc3_mem_access;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_type = 2'b00;
   logic [15:0] req_addr = 16'h0;
   logic [15:0] req_wdata = 16'h0;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_rd;
   logic [15:0] mem_dout;
   logic        mem_complete = 1'b1;

   lc3_mem_access #(.DATA_W(16)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd),
      .mem_dout(mem_dout), .mem_complete(mem_complete)
   );

   always #5 clock = ~clock;

   logic [15:0] mem [0:65535];
   logic        mem_init = 1'b1;
   assign mem_dout = mem[mem_addr];

   always @(posedge clock) begin
      if (mem_init) begin
         mem[16'h0010] <= 16'hBEEF;
         mem[16'h0020] <= 16'h0000;
         mem[16'h0030] <= 16'h0040;
         mem[16'h0040] <= 16'h5A5A;
         mem[16'h0050] <= 16'h0000;
      end else if (!mem_rd && mem_complete) begin
         mem[mem_addr] <= mem_din;
      end
   end

   int cyc = 0;
   int wr_cycles = 0;
   int acc_cnt = 0;
   logic [15:0] last_wr_addr = 16'h0;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) if (!reset && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
   always @(negedge clock) if (!mem_rd) begin
      wr_cycles    <= wr_cycles + 1;
      last_wr_addr <= mem_addr;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] data;
      int          cyc;
      string       name;
   } exp_t;
   exp_t sb[$];

   always @(negedge clock) begin
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_data"}, {16'h0, rsp_data}, {16'h0, e.data});
            chk({e.name, "_cycle"}, cyc, e.cyc);
         end
      end
   end

   task automatic wait_ready();
      @(negedge clock);
      for (int i = 0; i < 30 && !req_ready; i++) @(negedge clock);
      if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic [1:0] t, input logic [15:0] a, input logic [15:0] w,
                        input logic [15:0] exp_d, input int lat, input string nm);
      wait_ready();
      req_type  = t;
      req_addr  = a;
      req_wdata = w;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      sb.push_back('{exp_d, cyc + lat - 1, nm});
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
      if (sb.size() != 0) begin
         chk("rsp_timeout", 32'd0, 32'd1);
         sb.delete();
      end
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w0;
      int a0;
      int acc0;
      repeat (3) @(posedge clock);
      #1;
      reset    = 1'b0;
      mem_init = 1'b0;
      @(negedge clock);
      chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
      chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
      chk("rst_mem_din", {16'h0, mem_din}, 32'h0);
      chk("rst_mem_rd", {31'h0, mem_rd}, 32'd1);

      // LD
      w0 = wr_cycles;
      issue(2'b00, 16'h0010, 16'h0, 16'hBEEF, 2, "ld_beef");
      @(negedge clock);
      chk("ld_addr", {16'h0, mem_addr}, 32'h0010);
      chk("ld_rd", {31'h0, mem_rd}, 32'd1);
      wait_done();
      chk("ld_no_write", wr_cycles - w0, 32'd0);

      // ST then LD
      w0 = wr_cycles;
      issue(2'b01, 16'h0020, 16'h1234, 16'hBEEF, 2, "st_20");
      @(negedge clock);
      chk("st_rd", {31'h0, mem_rd}, 32'd0);
      chk("st_din", {16'h0, mem_din}, 32'h1234);
      wait_done();
      chk("st_write_cycles", wr_cycles - w0, 32'd1);
      chk("st_write_addr", {16'h0, last_wr_addr}, 32'h0020);
      chk("st_mem", {16'h0, mem[16'h0020]}, 32'h1234);
      issue(2'b00, 16'h0020, 16'h0, 16'h1234, 2, "ld_20");
      wait_done();

      // LDI then STI
      issue(2'b10, 16'h0030, 16'h0, 16'h5A5A, 3, "ldi_30");
      @(negedge clock);
      chk("ldi_ptr_addr", {16'h0, mem_addr}, 32'h0030);
      chk("ldi_ptr_rd", {31'h0, mem_rd}, 32'd1);
      @(negedge clock);
      chk("ldi_acc_addr", {16'h0, mem_addr}, 32'h0040);
      wait_done();
      issue(2'b11, 16'h0030, 16'h00FF, 16'h5A5A, 3, "sti_30");
      wait_done();
      chk("sti_target", {16'h0, mem[16'h0040]}, 32'h00FF);
      chk("sti_ptr_kept", {16'h0, mem[16'h0030]}, 32'h0040);

      // ST with 4 stall cycles in ACCESS
      issue(2'b01, 16'h0050, 16'hCAFE, 16'h5A5A, 6, "st_stall");
      mem_complete = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("stall_rd", {31'h0, mem_rd}, 32'd0);
         chk("stall_addr", {16'h0, mem_addr}, 32'h0050);
         @(posedge clock);
      end
      #1;
      mem_complete = 1'b1;
      wait_done();
      chk("stall_mem", {16'h0, mem[16'h0050]}, 32'hCAFE);

      // Reset while in PTR of an LDI
      wait_ready();
      req_type  = 2'b10;
      req_addr  = 16'h0030;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(negedge clock);
      chk("abort_in_ptr", {16'h0, mem_addr}, 32'h0030);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("abort_ready", {31'h0, req_ready}, 32'd1);
      chk("abort_rd", {31'h0, mem_rd}, 32'd1);
      chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      repeat (5) @(negedge clock);
      chk("abort_mem30", {16'h0, mem[16'h0030]}, 32'h0040);
      chk("abort_mem40", {16'h0, mem[16'h0040]}, 32'h00FF);

      // req_valid held high across busy cycles
      wait_ready();
      acc0      = acc_cnt;
      req_type  = 2'b00;
      req_addr  = 16'h0010;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      a0 = cyc;
      sb.push_back('{16'hBEEF, a0 + 1, "held_0"});
      sb.push_back('{16'hBEEF, a0 + 4, "held_1"});
      sb.push_back('{16'hBEEF, a0 + 7, "held_2"});
      repeat (6) @(posedge clock);
      #1;
      req_valid = 1'b0;
      wait_done();
      chk("held_accepts", acc_cnt - acc0, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
